// File: rtl/alu_ctrl_seq_pkg.sv
// Shared types and constants for the ALU control sequencer.
// Holds the opcode enum, FSM state codes, instruction-field constants and
// a small decode helper used by the sequencer top.
package alu_ctrl_seq_pkg;

  localparam int unsigned PC_W_DEF = 10;
  localparam int unsigned INSTR_W  = 9;
  localparam int unsigned CMD_W    = 7;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned REG_W    = 2;
  localparam int unsigned IMM_W    = 8;
  localparam int unsigned STATE_W  = 3;

  // Major opcode, instruction bits [8:6]
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_BEQ = 3'b001,
    OP_SB  = 3'b010,
    OP_LBU = 3'b011,
    OP_XOR = 3'b100,
    OP_OR  = 3'b101,
    OP_AND = 3'b110,
    OP_SRL = 3'b111
  } op_e;

  // Sequencer state codes
  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH     = 3'd1;
  localparam logic [STATE_W-1:0] S_DECODE    = 3'd2;
  localparam logic [STATE_W-1:0] S_EXEC      = 3'd3;
  localparam logic [STATE_W-1:0] S_MEM       = 3'd4;
  localparam logic [STATE_W-1:0] S_FETCH_IMM = 3'd5;
  localparam logic [STATE_W-1:0] S_LI_EXEC   = 3'd6;
  localparam logic [STATE_W-1:0] S_HALT      = 3'd7;

  // ADD/MOV with this sub-field is the first word of a two-word load-immediate
  localparam logic [1:0]         LI_SUB     = 2'b11;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  // True when the word is the opcode word of a load-immediate pair
  function automatic logic is_li(input logic [INSTR_W-1:0] w);
    return (op_e'(w[8:6]) == OP_ADD) && (w[1:0] == LI_SUB);
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_flag_reg.sv
// ALU flag register {carry, zero, parity}.
// Ports:
//   clk, rst_n : clock and synchronous active-low clear
//   clr        : synchronous clear (used when a new program run starts)
//   ld         : load enable, captures d at the rising edge
//   d          : incoming ALU flags
//   q          : registered flags
module alu_flag_reg
  import alu_ctrl_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ld,
  input  logic [FLAG_W-1:0] d,
  output logic [FLAG_W-1:0] q
);

  // Clear has priority over load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle control sequencer for the 8-bit ALU.
// Fetches 9-bit words from a synchronous instruction ROM, decodes them and
// drives the ALU controls, resolves BEQ, sequences SB/LBU through a
// data-memory req/ack handshake and expands two-word LI into one write.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : begin a run at PC 0 (accepted in IDLE/HALT only)
//   imem_addr, imem_data  : instruction ROM address / read data (1-cycle latency)
//   alu_cmd, ALUSrc, li   : ALU operation, immediate select, LI qualifier
//   regDst, imm, sc_i     : destination register, immediate, carry-in
//   alu_sc_o/zero/pari    : ALU result flags
//   rf_we                 : register-file write strobe
//   dm_req, dm_we, dm_ack : data-memory handshake
//   flags                 : {carry, zero, parity}
//   done                  : high while halted
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [CMD_W-1:0]   alu_cmd,
  output logic               ALUSrc,
  output logic               li,
  output logic [REG_W-1:0]   regDst,
  output logic [IMM_W-1:0]   imm,
  output logic               sc_i,
  input  logic               alu_sc_o,
  input  logic               alu_zero,
  input  logic               alu_pari,
  output logic               rf_we,
  output logic               dm_req,
  output logic               dm_we,
  input  logic               dm_ack,
  output logic [FLAG_W-1:0]  flags,
  output logic               done
);

  logic [STATE_W-1:0] state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt;
  logic               flag_ld;
  logic               flag_clr;
  op_e                op;
  logic [PC_W-1:0]    br_off;
  logic [PC_W-1:0]    pc_beq;

  assign op = op_e'(ir[8:6]);

  // pc already points past the BEQ word, so step back one before adding the offset
  assign br_off = PC_W'($signed(ir[5:0]));
  assign pc_beq = pc - PC_W'(1) + br_off;

  // Flag register; cleared whenever a new run is accepted
  alu_flag_reg u_flags (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flag_clr),
    .ld    (flag_ld),
    .d     ({alu_sc_o, alu_zero, alu_pari}),
    .q     (flags)
  );

  assign sc_i = flags[2];

  // Next-state, PC/IR update and output decode
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    flag_ld   = 1'b0;
    flag_clr  = 1'b0;
    imem_addr = pc;
    alu_cmd   = '0;
    ALUSrc    = 1'b0;
    li        = 1'b0;
    regDst    = '0;
    imm       = '0;
    rf_we     = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    done      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
          flag_clr  = 1'b1;
        end
      end

      S_FETCH: begin
        state_nxt = S_DECODE;
      end

      S_DECODE: begin
        ir_nxt = imem_data;
        pc_nxt = pc + PC_W'(1);
        if (imem_data == HALT_INSTR) begin
          state_nxt = S_HALT;
        end else if (is_li(imem_data)) begin
          state_nxt = S_FETCH_IMM;
        end else begin
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_cmd = {ir[8:6], ir[3:0]};
        regDst  = ir[5:4];
        case (op)
          OP_BEQ: begin
            // ALU result 1 (zero flag low) means the compare matched
            if (!alu_zero) begin
              pc_nxt = pc_beq;
            end
            state_nxt = S_FETCH;
          end
          OP_SB, OP_LBU: begin
            state_nxt = S_MEM;
          end
          default: begin
            rf_we     = 1'b1;
            flag_ld   = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        alu_cmd = {ir[8:6], ir[3:0]};
        regDst  = ir[5:4];
        dm_req  = 1'b1;
        dm_we   = (op == OP_SB);
        if (dm_ack) begin
          rf_we     = (op == OP_LBU);
          state_nxt = S_FETCH;
        end
      end

      S_FETCH_IMM: begin
        state_nxt = S_LI_EXEC;
      end

      S_LI_EXEC: begin
        // Immediate word arrives from the ROM this cycle and goes straight to the ALU
        imm       = imem_data[IMM_W-1:0];
        ALUSrc    = 1'b1;
        li        = 1'b1;
        regDst    = ir[5:4];
        rf_we     = 1'b1;
        pc_nxt    = pc + PC_W'(1);
        state_nxt = S_FETCH;
      end

      S_HALT: begin
        done = 1'b1;
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
          flag_clr  = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC and instruction registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

endmodule
